// File: rtl/mult_pkg.sv
// Shared types and the range-check helper for the filter datapath blocks.
package mult_pkg;

  typedef enum logic {
    RND_TRUNC   = 1'b0,
    RND_HALF_UP = 1'b1
  } round_mode_e;

  // Working width of sat_narrow; callers sign-extend into it and cast the
  // result back down to their own output width.
  localparam int SAT_W = 64;

  typedef struct packed {
    logic [SAT_W-1:0] val;
    logic             ovf;
  } sat_res_t;

  // Range check against a signed out_width-bit word. Out-of-range values are
  // either clamped to the nearer bound or passed through for the caller to
  // truncate (wrap); ovf flags both cases.
  function automatic sat_res_t sat_narrow(input logic signed [SAT_W-1:0] value,
                                          input int                      out_width,
                                          input logic                    sat_en);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    sat_res_t                res;
    hi      = (64'sd1 <<< (out_width - 1)) - 64'sd1;
    lo      = -hi - 64'sd1;
    res.val = value;
    res.ovf = 1'b0;
    if (value > hi) begin
      res.ovf = 1'b1;
      if (sat_en) res.val = hi;
    end else if (value < lo) begin
      res.ovf = 1'b1;
      if (sat_en) res.val = lo;
    end
    return res;
  endfunction

endpackage

// File: rtl/mult_round_sat.sv
// Combinational rescale of the full product: optional round-half-up bias,
// arithmetic right shift, then clamp or wrap into the output word.
module mult_round_sat
  import mult_pkg::*;
#(
  parameter int PROD_WIDTH = 12,
  parameter int OUT_WIDTH  = 6,
  parameter int FRAC_SHIFT = 5,
  parameter int ROUND_MODE = 0,
  parameter int SAT_EN     = 1
) (
  input  logic signed [PROD_WIDTH-1:0] prod,
  output logic signed [OUT_WIDTH-1:0]  out_data,
  output logic                         ovf
);

  // With no fractional bits to discard there is nothing to round.
  localparam int BIAS_SH = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
  localparam logic signed [PROD_WIDTH:0] BIAS =
    (ROUND_MODE == int'(RND_HALF_UP) && FRAC_SHIFT > 0) ?
      ((PROD_WIDTH+1)'(1) << BIAS_SH) : '0;

  logic signed [PROD_WIDTH:0] biased;
  logic signed [PROD_WIDTH:0] shifted;
  logic signed [SAT_W-1:0]    wide;
  sat_res_t                   res;

  // One extra bit of headroom keeps the bias add from overflowing.
  always_comb begin
    biased   = $signed({prod[PROD_WIDTH-1], prod}) + BIAS;
    shifted  = biased >>> FRAC_SHIFT;
    wide     = SAT_W'(shifted);
    res      = sat_narrow(wide, OUT_WIDTH, SAT_EN != 0);
    out_data = OUT_WIDTH'(res.val);
    ovf      = res.ovf;
  end

endmodule

// File: rtl/mult_pipe.sv
// Pipelined signed fixed-point multiplier with rounding, saturation and a
// valid/ready handshake. All stages advance together on a single enable.
module mult_pipe
  import mult_pkg::*;
#(
  parameter int DATA_WIDTH  = 6,
  parameter int COEFF_WIDTH = 6,
  parameter int OUT_WIDTH   = DATA_WIDTH,
  parameter int FRAC_SHIFT  = COEFF_WIDTH - 1,
  parameter int LATENCY     = 2,
  parameter int ROUND_MODE  = 0,
  parameter int SAT_EN      = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic signed [COEFF_WIDTH-1:0] in_coeff,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [OUT_WIDTH-1:0]   out_data,
  output logic                          out_ovf
);

  localparam int PROD_WIDTH = DATA_WIDTH + COEFF_WIDTH;

  logic                         en;
  logic [LATENCY-1:0]           vld_q, vld_d;
  logic signed [PROD_WIDTH-1:0] product;
  logic signed [PROD_WIDTH-1:0] fin_prod;
  logic                         fin_vld;
  logic signed [OUT_WIDTH-1:0]  rs_data;
  logic                         rs_ovf;
  logic signed [OUT_WIDTH-1:0]  out_data_q, out_data_d;
  logic                         out_ovf_q, out_ovf_d;

  assign en        = !vld_q[LATENCY-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[LATENCY-1];
  assign out_data  = out_data_q;
  assign out_ovf   = out_ovf_q;
  assign product   = PROD_WIDTH'(in_data) * PROD_WIDTH'(in_coeff);

  if (LATENCY == 1) begin : g_lat1
    assign fin_prod = product;
    assign fin_vld  = in_valid;
  end else begin : g_latn
    logic signed [PROD_WIDTH-1:0] prod_q [LATENCY-1];
    logic signed [PROD_WIDTH-1:0] prod_d [LATENCY-1];

    // Product register followed by pure delay stages; each loads only when
    // a valid beat moves into it.
    always_comb begin
      prod_d = prod_q;
      if (en && in_valid) prod_d[0] = product;
      for (int i = 1; i < LATENCY - 1; i++) begin
        if (en && vld_q[i-1]) prod_d[i] = prod_q[i-1];
      end
    end

    // Product and delay registers.
    always_ff @(posedge clk) begin
      for (int i = 0; i < LATENCY - 1; i++) begin
        if (rst) prod_q[i] <= '0;
        else     prod_q[i] <= prod_d[i];
      end
    end

    assign fin_prod = prod_q[LATENCY-2];
    assign fin_vld  = vld_q[LATENCY-2];
  end

  mult_round_sat #(
    .PROD_WIDTH (PROD_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH),
    .FRAC_SHIFT (FRAC_SHIFT),
    .ROUND_MODE (ROUND_MODE),
    .SAT_EN     (SAT_EN)
  ) u_round_sat (
    .prod     (fin_prod),
    .out_data (rs_data),
    .ovf      (rs_ovf)
  );

  // Valid chain: shifts as a whole on enable, holds (bubbles included) otherwise.
  always_comb begin
    vld_d = vld_q;
    if (en) begin
      vld_d[0] = in_valid;
      for (int i = 1; i < LATENCY; i++) vld_d[i] = vld_q[i-1];
    end
  end

  // Final stage captures the rescaled result only when a valid beat lands.
  always_comb begin
    out_data_d = out_data_q;
    out_ovf_d  = out_ovf_q;
    if (en && fin_vld) begin
      out_data_d = rs_data;
      out_ovf_d  = rs_ovf;
    end
  end

  // Valid bits and output registers; reset discards every in-flight beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q      <= '0;
      out_data_q <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      vld_q      <= vld_d;
      out_data_q <= out_data_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: doc/mult_pipe.md
# mult_pipe

Pipelined, parametrised signed fixed-point multiplier for the interpolation filter datapath. It multiplies a data sample by a Q1.(COEFF_WIDTH-1) tap coefficient and rescales the product back to an output word. It adds three things a plain combinational multiplier lacks: selectable rounding, optional saturation with an overflow flag, and a valid/ready handshake with configurable pipeline depth. Tap multipliers use it where timing closure or downstream backpressure demands registered arithmetic.

## Interface
Parameters:
- DATA_WIDTH, 6: signed input sample width.
- COEFF_WIDTH, 6: signed coefficient width, format Q1.(COEFF_WIDTH-1).
- OUT_WIDTH, DATA_WIDTH: signed output width.
- FRAC_SHIFT, COEFF_WIDTH-1: right shift applied to the full product.
- LATENCY, 2: pipeline stages, legal range 1..4.
- ROUND_MODE, 0: 0 = truncate (floor), 1 = round-half-up.
- SAT_EN, 1: 1 = saturate to the OUT_WIDTH range, 0 = wrap (keep the low OUT_WIDTH bits).

Ports:
- clk, in, 1: single clock, rising edge.
- rst, in, 1: synchronous, active-high reset.
- in_valid, in, 1: input beat valid.
- in_ready, out, 1: block accepts a beat this cycle.
- in_data, in, DATA_WIDTH: signed sample.
- in_coeff, in, COEFF_WIDTH: signed coefficient, sampled together with in_data.
- out_valid, out, 1: output beat valid.
- out_ready, in, 1: downstream accepts.
- out_data, out, OUT_WIDTH: scaled product.
- out_ovf, out, 1: the beat was clamped (SAT_EN=1) or wrapped (SAT_EN=0).

## Operation
- Full product: p = in_data * in_coeff, signed, DATA_WIDTH+COEFF_WIDTH bits. The full width is kept, so the MSB is never dropped.
- Rounding: ROUND_MODE=1 adds 2^(FRAC_SHIFT-1) to p before the shift. If FRAC_SHIFT=0, no bias is added. The add is done at DATA_WIDTH+COEFF_WIDTH+1 bits so it cannot overflow.
- Shift: arithmetic right shift by FRAC_SHIFT, which floors toward minus infinity.
- Range check: the result r is compared against [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Out of range with SAT_EN=1: clamp to the nearer bound and set ovf=1.
  - Out of range with SAT_EN=0: out_data = r[OUT_WIDTH-1:0] and set ovf=1.
  - In range: ovf=0.
- Pipeline:
  - Stage 1 registers the product.
  - Round, shift and saturate occupy the final stage.
  - Extra stages (LATENCY>2) are pure delay, placed before the final stage.
  - With LATENCY=1, multiply, round and saturate all happen in one registered stage.
- Handshake:
  - Global advance enable en = !out_valid || out_ready.
  - in_ready = en.
  - A beat is accepted when in_valid && in_ready.
  - When en=0, all stages hold; bubbles are not collapsed.
  - Each stage carries a valid bit; data registers load only when their stage advances.
- Data and the coefficient are captured in the same cycle. The coefficient may change every beat.

## Timing
- Latency: an accepted beat appears on out_valid exactly LATENCY cycles later, provided out_ready stayed high.
- Throughput: one beat per cycle when out_ready is held high.
- Stall: while out_valid=1 and out_ready=0, out_data and out_ovf hold stable and in_ready=0 in the same cycle (combinational path from out_ready).
- Reset: the cycle after rst is sampled high, all stage valid bits are 0, out_valid=0, out_data=0, out_ovf=0. in_ready reads 1 while out_valid=0.
- Reset mid-operation: in-flight beats are discarded and no partial output is emitted. A beat presented in the same cycle as rst is dropped.
- Simultaneous out_ready and in_valid at a full pipeline: the output pops and the input is accepted in the same cycle, so there is no bubble.

## Structure
- Shared package mult_pkg holds:
  - typedef enum round_mode_e {RND_TRUNC, RND_HALF_UP};
  - localparam PROD_WIDTH = DATA_WIDTH+COEFF_WIDTH (computed per instance, not a package constant);
  - function sat_narrow (range check plus clamp/wrap, returns value and ovf), reused by other filter blocks.
- One natural sub-module: mult_round_sat, purely combinational. It takes the full product and produces {out_data, ovf}, parametrised by the widths, FRAC_SHIFT, ROUND_MODE and SAT_EN.
- mult_pipe itself contains the product register, the delay stages, the valid chain and the handshake.

## Test plan
Defaults unless stated: DW=CW=OW=6, FRAC_SHIFT=5, LATENCY=2.
- in_data=16, in_coeff=16, trunc -> out_data=8, ovf=0; out_valid rises 2 cycles after acceptance.
- ROUND_MODE=1: in=31, coeff=1 -> out 1. ROUND_MODE=0, same inputs -> out 0. in=-1, coeff=1 -> trunc -1, round 0.
- in=-32, coeff=-32 (product 1024, r=32) -> SAT_EN=1: out 31, ovf=1; SAT_EN=0: out -32, ovf=1.
- Streaming 8 beats with out_ready toggling 1,0,0,1,...:
  - outputs match the model in order, with no loss or duplication;
  - out_data stays stable during stalls;
  - in_ready equals !out_valid || out_ready every cycle.
- Assert rst with 2 beats in flight -> next cycle out_valid=0, out_data=0, out_ovf=0; no stale beat appears afterwards.
- LATENCY=1 and LATENCY=4 sweeps with random in/coeff and out_ready held at 1 -> latency is exactly 1 and 4 respectively, with one result per cycle matching the model.
